load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 32 +++
 rtl/lsu_align.sv | 49 ++++
 rtl/load_store_unit.sv | 120 ++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, RV32I
// funct3 width codes, lane count and the default BUSY timeout.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  localparam int NUM_LANES   = 4;
  localparam int LSU_TIMEOUT = 64;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;

  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    if (is_store) return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store strobes, lane-replicated write data and
// load byte/half extraction with sign or zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [NUM_LANES-1:0][7:0] wlane, rlane;
  logic [7:0]  bsel;
  logic [15:0] hsel;
  logic        sx;

  assign rlane     = rdata;
  assign wdata_rep = wlane;
  assign sx        = ~funct3[2];

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign wlane[g] = (funct3[1:0] == SZ_B) ? wdata[7:0] :
                      (funct3[1:0] == SZ_H) ? wdata[8*(g%2) +: 8] :
                                              wdata[8*g +: 8];
  end

  // Misaligned low bits are dropped: halves use addr[1] only, words use none.
  always_comb begin
    bsel      = rlane[addr_lo];
    hsel      = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    wstrb     = 4'hf;
    rdata_ext = rdata;
    case (funct3[1:0])
      SZ_B: begin
        wstrb     = 4'b0001 << addr_lo;
        rdata_ext = {{24{sx & bsel[7]}}, bsel};
      end
      SZ_H: begin
        wstrb     = 4'b0011 << {addr_lo[1], 1'b0};
        rdata_ext = {{16{sx & hsel[15]}}, hsel};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: IDLE/BUSY/DONE handshake to a word memory with a
// BUSY timeout. Define LSU_MISALIGN_TRAP_EN to fault misaligned half/word accesses.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = LSU_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        err,
  output logic        mem_valid,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  lsu_state_t    state, nxt;
  logic          is_store_q;
  logic [2:0]    funct3_q;
  logic [31:0]   addr_q, wdata_q;
  logic [CW-1:0] cnt;
  logic          legal, misalign, tmo, busy;
  logic [3:0]    strb;
  logic [31:0]   wrep, rext;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = ((req_funct3[1:0] == SZ_H) && req_addr[0]) ||
                    ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign legal = f3_legal(req_is_store, req_funct3) && !misalign;
  assign tmo   = (cnt == CW'(TIMEOUT - 1));
  assign busy  = (state == BUSY);

  lsu_align u_align (
    .funct3    (funct3_q),
    .addr_lo   (addr_q[1:0]),
    .wdata     (wdata_q),
    .rdata     (mem_rdata),
    .wstrb     (strb),
    .wdata_rep (wrep),
    .rdata_ext (rext)
  );

  // Memory side is a pure function of the captured request, so it cannot move during BUSY.
  assign mem_valid  = busy;
  assign mem_we     = busy & is_store_q;
  assign mem_wstrb  = (busy & is_store_q) ? strb : 4'b0000;
  assign mem_addr   = {addr_q[31:2], 2'b00};
  assign mem_wdata  = wrep;
  assign resp_valid = (state == DONE);
  assign stall      = ((state == IDLE) & req_valid) | busy;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (req_valid) nxt = legal ? BUSY : DONE;
      BUSY:    if (mem_ready || tmo) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      is_store_q <= 1'b0;
      funct3_q   <= 3'b000;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt        <= '0;
      resp_rdata <= '0;
      err        <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          is_store_q <= req_is_store;
          funct3_q   <= req_funct3;
          addr_q     <= req_addr;
          wdata_q    <= req_wdata;
          cnt        <= '0;
          if (!legal) begin
            err        <= 1'b1;
            resp_rdata <= '0;
          end
        end
        BUSY: if (mem_ready) begin
          resp_rdata <= is_store_q ? 32'h0 : rext;
          err        <= 1'b0;
        end else if (tmo) begin
          resp_rdata <= '0;
          err        <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
        default: err <= 1'b0;
      endcase
    end
  end

endmodule
